// File: rtl/oled_spi_byte_tx.sv
// SSD1306 4-wire SPI byte transmitter: one byte plus D/C flag per valid/ready
// handshake, shifted out MSB-first with SCLK idling high and no chip select.
//
// state | meaning
// IDLE  | waiting for a byte, SCLK high, s_ready high
// LOW   | SCLK low half-period; SDIN was updated on entry
// HIGH  | SCLK high half-period; panel samples SDIN on entry
// GAP   | post-byte settle time with SCLK high
// DONE  | one-cycle completion pulse; may accept the next byte
module oled_spi_byte_tx #(
  parameter int CLK_DIV    = 4,
  parameter int GAP_CYCLES = 2
) (
  input  logic       ACLK,
  input  logic       ARESETN,
  input  logic [7:0] s_data,
  input  logic       s_dc,
  input  logic       s_valid,
  output logic       s_ready,
  output logic       busy,
  output logic       done,
  output logic       oled_sclk,
  output logic       oled_sdin,
  output logic       oled_dc
);

  typedef enum logic [2:0] {ST_IDLE, ST_LOW, ST_HIGH, ST_GAP, ST_DONE} state_t;

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
  localparam logic [7:0] GAP_LAST = 8'(GAP_CYCLES - 1);

  state_t     state, state_nxt;
  logic [7:0] div_cnt, div_nxt;
  logic [2:0] bit_cnt, bit_nxt;
  logic [6:0] shift_reg, shift_nxt;
  logic       sclk_nxt, sdin_nxt, dc_nxt;
  logic       accept;

  // Ready depends only on state, so s_valid never reaches s_ready combinationally.
  assign s_ready = (state == ST_IDLE) || (state == ST_DONE);
  assign busy    = !s_ready;
  assign done    = (state == ST_DONE);
  assign accept  = s_valid && s_ready;

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state     <= ST_IDLE;
      div_cnt   <= 8'd0;
      bit_cnt   <= 3'd0;
      shift_reg <= 7'd0;
      oled_sclk <= 1'b1;
      oled_sdin <= 1'b0;
      oled_dc   <= 1'b0;
    end else begin
      state     <= state_nxt;
      div_cnt   <= div_nxt;
      bit_cnt   <= bit_nxt;
      shift_reg <= shift_nxt;
      oled_sclk <= sclk_nxt;
      oled_sdin <= sdin_nxt;
      oled_dc   <= dc_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    div_nxt   = div_cnt;
    bit_nxt   = bit_cnt;
    shift_nxt = shift_reg;
    sclk_nxt  = oled_sclk;
    sdin_nxt  = oled_sdin;
    dc_nxt    = oled_dc;
    case (state)
      ST_IDLE, ST_DONE: begin
        sclk_nxt = 1'b1;
        if (accept) begin
          // Bit 7 goes straight onto SDIN; the shifter keeps only the remaining bits.
          shift_nxt = s_data[6:0];
          sdin_nxt  = s_data[7];
          dc_nxt    = s_dc;
          bit_nxt   = 3'd7;
          div_nxt   = 8'd0;
          sclk_nxt  = 1'b0;
          state_nxt = ST_LOW;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      ST_LOW: begin
        if (div_cnt == DIV_LAST) begin
          sclk_nxt  = 1'b1;
          div_nxt   = 8'd0;
          state_nxt = ST_HIGH;
        end else begin
          div_nxt = div_cnt + 8'd1;
        end
      end
      ST_HIGH: begin
        if (div_cnt == DIV_LAST) begin
          div_nxt = 8'd0;
          if (bit_cnt != 3'd0) begin
            bit_nxt   = bit_cnt - 3'd1;
            sdin_nxt  = shift_reg[6];
            shift_nxt = {shift_reg[5:0], 1'b0};
            sclk_nxt  = 1'b0;
            state_nxt = ST_LOW;
          end else if (GAP_CYCLES == 0) begin
            state_nxt = ST_DONE;
          end else begin
            state_nxt = ST_GAP;
          end
        end else begin
          div_nxt = div_cnt + 8'd1;
        end
      end
      ST_GAP: begin
        if (div_cnt == GAP_LAST) begin
          div_nxt   = 8'd0;
          state_nxt = ST_DONE;
        end else begin
          div_nxt = div_cnt + 8'd1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_oled_spi_byte_tx.sv
// Scoreboard bench for oled_spi_byte_tx: instance 0 uses CLK_DIV=2/GAP=3,
// instance 1 uses CLK_DIV=1/GAP=0; monitors decode SDIN on SCLK rising edges.
module tb_oled_spi_byte_tx;
  localparam int DIV_A = 2;
  localparam int GAP_A = 3;
  localparam int DIV_B = 1;
  localparam int GAP_B = 0;
  localparam int LAT_A = 16 * DIV_A + GAP_A;
  localparam int LAT_B = 16 * DIV_B + GAP_B;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [1:0] valid = 2'b00;
  logic [1:0] dc_in = 2'b00;
  logic [7:0] data_a = 8'h00;
  logic [7:0] data_b = 8'h00;
  logic [1:0] ready, busy, done, sclk, sdin, dc_out;
  int         tests_run = 0;
  int         tests_failed = 0;
  int         cyc = 0;

  typedef struct {
    logic [7:0] data;
    int         nbits;
    logic       dc;
    int         k;
    int         lat;
    int         busy_cyc;
    int         first_rise;
    int         bad_spacing;
    int         glitches;
    bit         spurious;
  } obs_t;

  obs_t       obs_a[$];
  obs_t       obs_b[$];
  logic [8:0] exp_a[$];
  logic [8:0] exp_b[$];

  oled_spi_byte_tx #(.CLK_DIV(DIV_A), .GAP_CYCLES(GAP_A)) dut_a (
    .ACLK(clk), .ARESETN(rst_n), .s_data(data_a), .s_dc(dc_in[0]), .s_valid(valid[0]),
    .s_ready(ready[0]), .busy(busy[0]), .done(done[0]),
    .oled_sclk(sclk[0]), .oled_sdin(sdin[0]), .oled_dc(dc_out[0])
  );

  oled_spi_byte_tx #(.CLK_DIV(DIV_B), .GAP_CYCLES(GAP_B)) dut_b (
    .ACLK(clk), .ARESETN(rst_n), .s_data(data_b), .s_dc(dc_in[1]), .s_valid(valid[1]),
    .s_ready(ready[1]), .busy(busy[1]), .done(done[1]),
    .oled_sclk(sclk[1]), .oled_sdin(sdin[1]), .oled_dc(dc_out[1])
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Observes one instance on falling ACLK edges; pushes one record per done pulse.
  task automatic monitor(input int g);
    int   div = (g == 0) ? DIV_A : DIV_B;
    obs_t o;
    bit   active = 1'b0;
    bit   dc_got = 1'b0;
    logic psclk = 1'b1;
    logic psdin = 1'b0;
    int   last_rise = 0;
    o = '{default: 0};
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        active = 1'b0;
      end else begin
        if (active) begin
          if (busy[g]) o.busy_cyc++;
          if (!dc_got) begin
            o.dc   = dc_out[g];
            dc_got = 1'b1;
          end
          if (sclk[g] && !psclk) begin
            if (o.nbits == 0) o.first_rise = cyc - o.k;
            else if (cyc - last_rise != 2 * div) o.bad_spacing++;
            last_rise = cyc;
            o.nbits++;
            o.data = {o.data[6:0], sdin[g]};
          end
          if (sdin[g] !== psdin && !(psclk && !sclk[g])) o.glitches++;
        end
        if (done[g]) begin
          if (!active) begin
            o = '{default: 0};
            o.spurious = 1'b1;
          end
          o.lat = cyc - o.k;
          if (g == 0) obs_a.push_back(o);
          else obs_b.push_back(o);
          active = 1'b0;
        end
        if (valid[g] && ready[g]) begin
          o      = '{default: 0};
          o.k    = cyc + 1;
          active = 1'b1;
          dc_got = 1'b0;
        end
      end
      psclk = sclk[g];
      psdin = sdin[g];
    end
  endtask

  initial monitor(0);
  initial monitor(1);

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Called at posedge+1; returns at posedge+1 right after the accepting edge, s_valid still high.
  task automatic send(input int g, input logic [7:0] b, input logic d);
    bit ok = 1'b0;
    valid[g] = 1'b1;
    dc_in[g] = d;
    if (g == 0) begin
      data_a = b;
      exp_a.push_back({d, b});
    end else begin
      data_b = b;
      exp_b.push_back({d, b});
    end
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clk);
      ok = ready[g];
      @(posedge clk);
      #1;
    end
    if (!ok) begin
      tests_run++;
      tests_failed++;
      $display("FAIL send_timeout: inst %0d byte %h never saw s_ready, want accept", g, b);
    end
  endtask

  task automatic wait_obs(input int g, input int n);
    for (int i = 0; i < 400; i++) begin
      if ((g == 0 ? obs_a.size() : obs_b.size()) >= n) break;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #1;
    tests_run++;
    if (sclk !== 2'b11 || sdin !== 2'b00 || dc_out !== 2'b00) begin
      tests_failed++;
      $display("FAIL reset_async_pins: sclk=%b sdin=%b dc=%b, want 11 00 00", sclk, sdin, dc_out);
    end
    tests_run++;
    if (busy !== 2'b00 || done !== 2'b00 || ready !== 2'b11) begin
      tests_failed++;
      $display("FAIL reset_async_flags: busy=%b done=%b ready=%b, want 00 00 11", busy, done, ready);
    end
    tick(3);
    rst_n = 1'b1;
    tick(2);
    tests_run++;
    if (sclk !== 2'b11 || sdin !== 2'b00 || dc_out !== 2'b00 || busy !== 2'b00 || ready !== 2'b11) begin
      tests_failed++;
      $display("FAIL reset_release: sclk=%b sdin=%b dc=%b busy=%b ready=%b, want 11 00 00 00 11",
               sclk, sdin, dc_out, busy, ready);
    end
  endtask

  task automatic test_idle();
    int bad = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (sclk !== 2'b11 || ready !== 2'b11 || done !== 2'b00) bad++;
    end
    tick(1);
    tests_run++;
    if (bad != 0 || obs_a.size() != 0 || obs_b.size() != 0) begin
      tests_failed++;
      $display("FAIL idle_quiet: bad_cycles=%0d dones=%0d/%0d, want 0 0/0", bad, obs_a.size(), obs_b.size());
    end
  endtask

  task automatic test_single_a5();
    obs_t o;
    logic [8:0] e;
    send(0, 8'hA5, 1'b1);
    valid[0] = 1'b0;
    @(negedge clk);
    tests_run++;
    if (dc_out[0] !== 1'b1 || sclk[0] !== 1'b0 || busy[0] !== 1'b1) begin
      tests_failed++;
      $display("FAIL a5_first_cycle: dc=%b sclk=%b busy=%b, want 1 0 1", dc_out[0], sclk[0], busy[0]);
    end
    tick(1);
    wait_obs(0, 1);
    tests_run++;
    if (obs_a.size() != 1 || exp_a.size() != 1) begin
      tests_failed++;
      $display("FAIL a5_done_count: got %0d dones, want 1", obs_a.size());
    end else begin
      o = obs_a.pop_front();
      e = exp_a.pop_front();
      tests_run++;
      if (o.data !== e[7:0] || o.nbits != 8 || o.spurious) begin
        tests_failed++;
        $display("FAIL a5_byte: got %h (%0d bits), want %h (8 bits)", o.data, o.nbits, e[7:0]);
      end
      tests_run++;
      if (o.dc !== e[8]) begin
        tests_failed++;
        $display("FAIL a5_dc: got %b, want %b", o.dc, e[8]);
      end
      tests_run++;
      if (o.lat != LAT_A || o.busy_cyc != LAT_A) begin
        tests_failed++;
        $display("FAIL a5_latency: done after %0d busy %0d, want %0d %0d", o.lat, o.busy_cyc, LAT_A, LAT_A);
      end
      tests_run++;
      if (o.first_rise != DIV_A || o.bad_spacing != 0 || o.glitches != 0) begin
        tests_failed++;
        $display("FAIL a5_sclk_timing: first_rise=%0d bad_spacing=%0d glitches=%0d, want %0d 0 0",
                 o.first_rise, o.bad_spacing, o.glitches, DIV_A);
      end
    end
    tick(20);
    tests_run++;
    if (obs_a.size() != 0 || sdin[0] !== 1'b1 || dc_out[0] !== 1'b1 || sclk[0] !== 1'b1) begin
      tests_failed++;
      $display("FAIL a5_hold: extra_dones=%0d sdin=%b dc=%b sclk=%b, want 0 1 1 1",
               obs_a.size(), sdin[0], dc_out[0], sclk[0]);
    end
  endtask

  task automatic test_back_to_back();
    obs_t o[2];
    logic [8:0] e;
    send(0, 8'hAE, 1'b0);
    send(0, 8'h8D, 1'b0);
    valid[0] = 1'b0;
    wait_obs(0, 2);
    tests_run++;
    if (obs_a.size() != 2 || exp_a.size() != 2) begin
      tests_failed++;
      $display("FAIL b2b_done_count: got %0d dones, want 2", obs_a.size());
    end else begin
      for (int j = 0; j < 2; j++) begin
        o[j] = obs_a.pop_front();
        e = exp_a.pop_front();
        tests_run++;
        if (o[j].data !== e[7:0] || o[j].nbits != 8 || o[j].dc !== e[8]) begin
          tests_failed++;
          $display("FAIL b2b_byte%0d: got %h/%0d bits dc=%b, want %h/8 dc=%b",
                   j, o[j].data, o[j].nbits, o[j].dc, e[7:0], e[8]);
        end
        tests_run++;
        if (o[j].lat != LAT_A || o[j].bad_spacing != 0 || o[j].glitches != 0) begin
          tests_failed++;
          $display("FAIL b2b_timing%0d: lat=%0d bad_spacing=%0d glitches=%0d, want %0d 0 0",
                   j, o[j].lat, o[j].bad_spacing, o[j].glitches, LAT_A);
        end
      end
      tests_run++;
      if (o[1].k - o[0].k != LAT_A + 1) begin
        tests_failed++;
        $display("FAIL b2b_period: got %0d cycles, want %0d", o[1].k - o[0].k, LAT_A + 1);
      end
    end
    tick(20);
    tests_run++;
    if (obs_a.size() != 0) begin
      tests_failed++;
      $display("FAIL b2b_extra_done: got %0d, want 0", obs_a.size());
    end
  endtask

  task automatic test_busy_ignore();
    obs_t o[2];
    logic [8:0] e;
    send(0, 8'h5A, 1'b1);
    valid[0] = 1'b0;
    tick(6);
    send(0, 8'hFF, 1'b0);
    valid[0] = 1'b0;
    wait_obs(0, 2);
    tests_run++;
    if (obs_a.size() != 2 || exp_a.size() != 2) begin
      tests_failed++;
      $display("FAIL ignore_done_count: got %0d dones, want 2", obs_a.size());
    end else begin
      for (int j = 0; j < 2; j++) begin
        o[j] = obs_a.pop_front();
        e = exp_a.pop_front();
        tests_run++;
        if (o[j].data !== e[7:0] || o[j].nbits != 8 || o[j].dc !== e[8] || o[j].lat != LAT_A) begin
          tests_failed++;
          $display("FAIL ignore_byte%0d: got %h/%0d bits dc=%b lat=%0d, want %h/8 dc=%b lat=%0d",
                   j, o[j].data, o[j].nbits, o[j].dc, o[j].lat, e[7:0], e[8], LAT_A);
        end
      end
      tests_run++;
      if (o[1].k - o[0].k != LAT_A + 1) begin
        tests_failed++;
        $display("FAIL ignore_accept_time: accepted %0d cycles after first, want %0d",
                 o[1].k - o[0].k, LAT_A + 1);
      end
    end
  endtask

  task automatic test_reset_mid();
    obs_t o;
    logic [8:0] e;
    send(0, 8'hF0, 1'b1);
    valid[0] = 1'b0;
    tick(14);
    #3;
    tests_run++;
    if (sclk[0] !== 1'b1 || sdin[0] !== 1'b1 || busy[0] !== 1'b1) begin
      tests_failed++;
      $display("FAIL midrst_before: sclk=%b sdin=%b busy=%b, want 1 1 1", sclk[0], sdin[0], busy[0]);
    end
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (sclk[0] !== 1'b1 || sdin[0] !== 1'b0 || dc_out[0] !== 1'b0 || busy[0] !== 1'b0 ||
        done[0] !== 1'b0 || ready[0] !== 1'b1) begin
      tests_failed++;
      $display("FAIL midrst_async: sclk=%b sdin=%b dc=%b busy=%b done=%b ready=%b, want 1 0 0 0 0 1",
               sclk[0], sdin[0], dc_out[0], busy[0], done[0], ready[0]);
    end
    exp_a.delete();
    tick(3);
    rst_n = 1'b1;
    tick(5);
    tests_run++;
    if (obs_a.size() != 0) begin
      tests_failed++;
      $display("FAIL midrst_no_done: got %0d dones, want 0", obs_a.size());
    end
    send(0, 8'h96, 1'b0);
    valid[0] = 1'b0;
    wait_obs(0, 1);
    tests_run++;
    if (obs_a.size() != 1 || exp_a.size() != 1) begin
      tests_failed++;
      $display("FAIL midrst_next_count: got %0d dones, want 1", obs_a.size());
    end else begin
      o = obs_a.pop_front();
      e = exp_a.pop_front();
      tests_run++;
      if (o.data !== e[7:0] || o.nbits != 8 || o.dc !== e[8] || o.lat != LAT_A || o.glitches != 0) begin
        tests_failed++;
        $display("FAIL midrst_next_byte: got %h/%0d bits dc=%b lat=%0d glitches=%0d, want %h/8 dc=%b lat=%0d 0",
                 o.data, o.nbits, o.dc, o.lat, o.glitches, e[7:0], e[8], LAT_A);
      end
    end
  endtask

  task automatic test_div1();
    obs_t o;
    logic [8:0] e;
    send(1, 8'h3C, 1'b0);
    valid[1] = 1'b0;
    wait_obs(1, 1);
    tests_run++;
    if (obs_b.size() != 1 || exp_b.size() != 1) begin
      tests_failed++;
      $display("FAIL div1_done_count: got %0d dones, want 1", obs_b.size());
    end else begin
      o = obs_b.pop_front();
      e = exp_b.pop_front();
      tests_run++;
      if (o.data !== e[7:0] || o.nbits != 8 || o.dc !== e[8]) begin
        tests_failed++;
        $display("FAIL div1_byte: got %h/%0d bits dc=%b, want %h/8 dc=%b", o.data, o.nbits, o.dc, e[7:0], e[8]);
      end
      tests_run++;
      if (o.lat != LAT_B || o.busy_cyc != LAT_B || o.first_rise != DIV_B || o.bad_spacing != 0) begin
        tests_failed++;
        $display("FAIL div1_timing: lat=%0d busy=%0d first_rise=%0d bad_spacing=%0d, want %0d %0d %0d 0",
                 o.lat, o.busy_cyc, o.first_rise, o.bad_spacing, LAT_B, LAT_B, DIV_B);
      end
    end
    tick(10);
    tests_run++;
    if (obs_b.size() != 0 || sdin[1] !== 1'b0 || sclk[1] !== 1'b1) begin
      tests_failed++;
      $display("FAIL div1_hold: extra_dones=%0d sdin=%b sclk=%b, want 0 0 1", obs_b.size(), sdin[1], sclk[1]);
    end
  endtask

  initial begin
    test_reset();
    test_idle();
    test_single_a5();
    test_back_to_back();
    test_busy_ignore();
    test_reset_mid();
    test_div1();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation still running at %0t, want finished", $time);
    $fatal(1, "timeout");
  end

endmodule
